// File: rtl/multicycle_ctlpath.sv
// Control FSM for the multicycle SiMPLE RISC-V core: FETCH/DECODE/EXECUTE/MEM/WRITEBACK over one shared bus.
// Optional retired-instruction counter output enabled by defining INSTRET_COUNTER_EN.
module multicycle_ctlpath #(
  parameter int unsigned RESET_STATE = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] inst_opcode,
  input  logic [2:0] inst_funct3,
  input  logic       alu_result_equal_zero,
  input  logic       mem_ready,
  output logic       inst_read_enable,
  output logic       inst_write_enable,
  output logic       operand_write_enable,
  output logic       pc_write_enable,
  output logic       regfile_write_enable,
  output logic       data_mem_read_enable,
  output logic       data_mem_write_enable,
  output logic       alu_operand_a_select,
  output logic       alu_operand_b_select,
  output logic [1:0] alu_op_type,
  output logic [1:0] reg_writeback_select,
  output logic [1:0] next_pc_select,
  output logic       illegal_inst
`ifdef INSTRET_COUNTER_EN
  ,
  output logic [31:0] instret
`endif
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_t;

  // Out-of-range reset encodings fall back to FETCH so the register always holds a legal state.
  localparam state_t RESET_STATE_E = (RESET_STATE <= 4) ? state_t'(RESET_STATE[2:0]) : FETCH;

  state_t state_q, state_d;

  logic is_load, is_store, is_op, is_op_imm, is_auipc, is_lui;
  logic is_branch, is_jal, is_jalr, is_misc_mem, is_system;
  logic is_illegal, is_nop, branch_taken;
  logic unused_funct3;

  assign unused_funct3 = inst_funct3[1];

  always_comb begin
    is_load     = (inst_opcode == OPC_LOAD);
    is_store    = (inst_opcode == OPC_STORE);
    is_op       = (inst_opcode == OPC_OP);
    is_op_imm   = (inst_opcode == OPC_OP_IMM);
    is_auipc    = (inst_opcode == OPC_AUIPC);
    is_lui      = (inst_opcode == OPC_LUI);
    is_branch   = (inst_opcode == OPC_BRANCH);
    is_jal      = (inst_opcode == OPC_JAL);
    is_jalr     = (inst_opcode == OPC_JALR);
    is_misc_mem = (inst_opcode == OPC_MISC_MEM);
    is_system   = (inst_opcode == OPC_SYSTEM);
    is_illegal  = !(is_load | is_store | is_op | is_op_imm | is_auipc | is_lui |
                    is_branch | is_jal | is_jalr | is_misc_mem | is_system);
    is_nop      = is_misc_mem | is_system | is_illegal;
    // funct3 bit0 inverts the sense (BNE/BGE/BGEU), bit2 selects SLT-style compares.
    branch_taken = alu_result_equal_zero ^ inst_funct3[0] ^ inst_funct3[2];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= RESET_STATE_E;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d               = state_q;
    inst_read_enable      = 1'b0;
    inst_write_enable     = 1'b0;
    operand_write_enable  = 1'b0;
    pc_write_enable       = 1'b0;
    regfile_write_enable  = 1'b0;
    data_mem_read_enable  = 1'b0;
    data_mem_write_enable = 1'b0;
    alu_operand_a_select  = 1'b0;
    alu_operand_b_select  = 1'b0;
    alu_op_type           = 2'd0;
    reg_writeback_select  = 2'd0;
    next_pc_select        = 2'd0;
    illegal_inst          = 1'b0;

    case (state_q)
      FETCH: begin
        inst_read_enable = 1'b1;
        if (mem_ready) begin
          inst_write_enable = 1'b1;
          state_d           = DECODE;
        end
      end

      DECODE: begin
        operand_write_enable = 1'b1;
        illegal_inst         = is_illegal;
        state_d              = EXECUTE;
      end

      EXECUTE: begin
        state_d = WRITEBACK;
        if (is_op) begin
          alu_op_type = 2'd2;
        end else if (is_op_imm) begin
          alu_operand_b_select = 1'b1;
          alu_op_type          = 2'd2;
        end else if (is_auipc) begin
          alu_operand_a_select = 1'b1;
          alu_operand_b_select = 1'b1;
        end else if (is_jalr) begin
          alu_operand_b_select = 1'b1;
        end else if (is_load || is_store) begin
          alu_operand_b_select = 1'b1;
          state_d              = MEM;
        end else if (is_branch) begin
          alu_op_type     = 2'd1;
          pc_write_enable = 1'b1;
          next_pc_select  = branch_taken ? 2'd1 : 2'd0;
          state_d         = FETCH;
        end
      end

      MEM: begin
        // Address operands stay selected so the bus address is stable across wait states.
        alu_operand_b_select = 1'b1;
        if (is_load) begin
          data_mem_read_enable = 1'b1;
          if (mem_ready) state_d = WRITEBACK;
        end else if (is_store) begin
          data_mem_write_enable = 1'b1;
          if (mem_ready) begin
            pc_write_enable = 1'b1;
            state_d         = FETCH;
          end
        end else begin
          state_d = WRITEBACK;
        end
      end

      WRITEBACK: begin
        pc_write_enable      = 1'b1;
        regfile_write_enable = !is_nop;
        if (is_load)                reg_writeback_select = 2'd1;
        else if (is_jal || is_jalr) reg_writeback_select = 2'd2;
        else if (is_lui)            reg_writeback_select = 2'd3;
        if (is_jal)       next_pc_select = 2'd1;
        else if (is_jalr) next_pc_select = 2'd2;
        if (is_jalr) alu_operand_b_select = 1'b1;
        state_d = FETCH;
      end

      default: state_d = FETCH;
    endcase

    // Reset silences every control line immediately, independent of the clock.
    if (!reset) begin
      inst_read_enable      = 1'b0;
      inst_write_enable     = 1'b0;
      operand_write_enable  = 1'b0;
      pc_write_enable       = 1'b0;
      regfile_write_enable  = 1'b0;
      data_mem_read_enable  = 1'b0;
      data_mem_write_enable = 1'b0;
      alu_operand_a_select  = 1'b0;
      alu_operand_b_select  = 1'b0;
      alu_op_type           = 2'd0;
      reg_writeback_select  = 2'd0;
      next_pc_select        = 2'd0;
      illegal_inst          = 1'b0;
    end
  end

`ifdef INSTRET_COUNTER_EN
  logic [31:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (pc_write_enable) instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctlpath.sv
// Self-checking bench for multicycle_ctlpath: vector table, hand sequences and a random instruction stream.
// Instret checks are compiled in when INSTRET_COUNTER_EN is defined.
module tb_multicycle_ctlpath;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] inst_opcode;
  logic [2:0] inst_funct3;
  logic       alu_result_equal_zero;
  logic       mem_ready;
  logic       inst_read_enable, inst_write_enable, operand_write_enable, pc_write_enable;
  logic       regfile_write_enable, data_mem_read_enable, data_mem_write_enable;
  logic       alu_operand_a_select, alu_operand_b_select;
  logic [1:0] alu_op_type, reg_writeback_select, next_pc_select;
  logic       illegal_inst;
`ifdef INSTRET_COUNTER_EN
  logic [31:0] instret;
`endif

  always #5 clock = ~clock;

  multicycle_ctlpath #(.RESET_STATE(0)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .inst_opcode           (inst_opcode),
    .inst_funct3           (inst_funct3),
    .alu_result_equal_zero (alu_result_equal_zero),
    .mem_ready             (mem_ready),
    .inst_read_enable      (inst_read_enable),
    .inst_write_enable     (inst_write_enable),
    .operand_write_enable  (operand_write_enable),
    .pc_write_enable       (pc_write_enable),
    .regfile_write_enable  (regfile_write_enable),
    .data_mem_read_enable  (data_mem_read_enable),
    .data_mem_write_enable (data_mem_write_enable),
    .alu_operand_a_select  (alu_operand_a_select),
    .alu_operand_b_select  (alu_operand_b_select),
    .alu_op_type           (alu_op_type),
    .reg_writeback_select  (reg_writeback_select),
    .next_pc_select        (next_pc_select),
    .illegal_inst          (illegal_inst)
`ifdef INSTRET_COUNTER_EN
    ,
    .instret               (instret)
`endif
  );

  int checks = 0;
  int errors = 0;
  int obs_cyc, obs_rd, obs_wr;
  logic [31:0] model_instret = '0;

  typedef enum {PH_F, PH_D, PH_E, PH_M, PH_W} ph_t;
  typedef enum {K_OP, K_IMM, K_AUIPC, K_LUI, K_JAL, K_JALR, K_LOAD, K_STORE, K_BR, K_NOP, K_ILL} kind_t;

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic       z;
    int         cyc;
    logic [1:0] wb;
    logic [1:0] npc;
    logic       rf;
    logic       ill;
  } vec_t;

  vec_t tbl[15];
  logic [6:0] legal_opc[11];

  function automatic kind_t classify(logic [6:0] o);
    case (o)
      7'b0110011: return K_OP;
      7'b0010011: return K_IMM;
      7'b0010111: return K_AUIPC;
      7'b0110111: return K_LUI;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BR;
      7'b0001111, 7'b1110011: return K_NOP;
      default: return K_ILL;
    endcase
  endfunction

  // {ire, iwe, owe, pcwe, rfwe, dre, dwe, a, b, op[2], wb[2], npc[2], ill}
  function automatic logic [15:0] dut_vec();
    return {inst_read_enable, inst_write_enable, operand_write_enable, pc_write_enable,
            regfile_write_enable, data_mem_read_enable, data_mem_write_enable,
            alu_operand_a_select, alu_operand_b_select, alu_op_type,
            reg_writeback_select, next_pc_select, illegal_inst};
  endfunction

  function automatic logic [15:0] expect_vec(ph_t ph, kind_t k, logic [2:0] f3, logic z, logic rdy);
    logic ire, iwe, owe, pcwe, rfwe, dre, dwe, a, b, ill;
    logic [1:0] op, wb, npc;
    {ire, iwe, owe, pcwe, rfwe, dre, dwe, a, b, ill} = '0;
    op = 2'd0; wb = 2'd0; npc = 2'd0;
    case (ph)
      PH_F: begin ire = 1'b1; iwe = rdy; end
      PH_D: begin owe = 1'b1; ill = (k == K_ILL); end
      PH_E: begin
        if (k == K_OP)    op = 2'd2;
        if (k == K_IMM)   begin b = 1'b1; op = 2'd2; end
        if (k == K_AUIPC) begin a = 1'b1; b = 1'b1; end
        if (k == K_JALR || k == K_LOAD || k == K_STORE) b = 1'b1;
        if (k == K_BR) begin
          op = 2'd1; pcwe = 1'b1;
          npc = ((z ^ f3[0] ^ f3[2]) == 1'b1) ? 2'd1 : 2'd0;
        end
      end
      PH_M: begin
        b = 1'b1;
        if (k == K_LOAD)  dre = 1'b1;
        if (k == K_STORE) begin dwe = 1'b1; pcwe = rdy; end
      end
      PH_W: begin
        pcwe = 1'b1;
        rfwe = !(k == K_NOP || k == K_ILL);
        if (k == K_LOAD) wb = 2'd1;
        if (k == K_JAL || k == K_JALR) wb = 2'd2;
        if (k == K_LUI) wb = 2'd3;
        if (k == K_JAL) npc = 2'd1;
        if (k == K_JALR) begin npc = 2'd2; b = 1'b1; end
      end
      default: ;
    endcase
    return {ire, iwe, owe, pcwe, rfwe, dre, dwe, a, b, op, wb, npc, ill};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Called at posedge+1 with inputs already applied; compares, then advances one clock.
  task automatic cycle_check(string nm, ph_t ph, kind_t k);
    logic [15:0] e;
    #1;
    e = expect_vec(ph, k, inst_funct3, alu_result_equal_zero, mem_ready);
    chk(nm, {16'h0, dut_vec()}, {16'h0, e});
`ifdef INSTRET_COUNTER_EN
    chk({nm, "_instret"}, instret, model_instret);
`endif
    if (data_mem_read_enable)  obs_rd++;
    if (data_mem_write_enable) obs_wr++;
    obs_cyc++;
    if (e[12]) model_instret++;
    tick();
  endtask

  // fw/mw >= 0 give fixed wait counts in FETCH/MEM; negative means random waits and garbage inputs.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input int fw, input int mw);
    kind_t k;
    int w;
    logic rdy;
    k = classify(opc);
    obs_cyc = 0; obs_rd = 0; obs_wr = 0;
    w = 0;
    do begin
      rdy = (fw >= 0) ? (w >= fw) : ((w >= 4) || ($urandom_range(0, 2) != 0));
      inst_opcode = (fw >= 0) ? opc : 7'($urandom);
      inst_funct3 = (fw >= 0) ? f3 : 3'($urandom);
      alu_result_equal_zero = 1'($urandom);
      mem_ready = rdy;
      cycle_check("fetch", PH_F, k);
      w++;
    end while (!rdy);
    inst_opcode = opc; inst_funct3 = f3;
    mem_ready = 1'($urandom); alu_result_equal_zero = 1'($urandom);
    cycle_check("decode", PH_D, k);
    mem_ready = 1'($urandom); alu_result_equal_zero = 1'($urandom);
    cycle_check("execute", PH_E, k);
    if (k == K_LOAD || k == K_STORE) begin
      w = 0;
      do begin
        rdy = (mw >= 0) ? (w >= mw) : ((w >= 4) || ($urandom_range(0, 2) != 0));
        mem_ready = rdy; alu_result_equal_zero = 1'($urandom);
        cycle_check("mem", PH_M, k);
        w++;
      end while (!rdy);
    end
    if (k != K_BR && k != K_STORE) begin
      mem_ready = 1'($urandom); alu_result_equal_zero = 1'($urandom);
      cycle_check("writeback", PH_W, k);
    end
  endtask

  task automatic run_fixed(input vec_t v, input int idx);
    int cyc;
    logic done, rf_seen, ill_seen;
    logic [1:0] wb, npc;
    inst_opcode = v.opc; inst_funct3 = v.f3;
    alu_result_equal_zero = v.z; mem_ready = 1'b1;
    cyc = 0; done = 1'b0; rf_seen = 1'b0; ill_seen = 1'b0; wb = 2'd0; npc = 2'd0;
    while (!done && cyc < 20) begin
      #1;
      cyc++;
      if (regfile_write_enable) rf_seen = 1'b1;
      if (illegal_inst) ill_seen = 1'b1;
      if (pc_write_enable) begin
        wb = reg_writeback_select; npc = next_pc_select; done = 1'b1;
        model_instret++;
      end
      tick();
    end
    chk($sformatf("tbl%0d_latency", idx), cyc, v.cyc);
    chk($sformatf("tbl%0d_wb_sel", idx), {30'h0, wb}, {30'h0, v.wb});
    chk($sformatf("tbl%0d_next_pc", idx), {30'h0, npc}, {30'h0, v.npc});
    chk($sformatf("tbl%0d_rf_we", idx), {31'h0, rf_seen}, {31'h0, v.rf});
    chk($sformatf("tbl%0d_illegal", idx), {31'h0, ill_seen}, {31'h0, v.ill});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            opc          f3    z     cyc wb     npc    rf    ill
    tbl[0]  = '{7'b0010011, 3'd0, 1'b0, 4, 2'd0, 2'd0, 1'b1, 1'b0}; // ADDI
    tbl[1]  = '{7'b0110011, 3'd0, 1'b0, 4, 2'd0, 2'd0, 1'b1, 1'b0}; // ADD
    tbl[2]  = '{7'b0110111, 3'd0, 1'b0, 4, 2'd3, 2'd0, 1'b1, 1'b0}; // LUI
    tbl[3]  = '{7'b0010111, 3'd0, 1'b0, 4, 2'd0, 2'd0, 1'b1, 1'b0}; // AUIPC
    tbl[4]  = '{7'b1101111, 3'd0, 1'b0, 4, 2'd2, 2'd1, 1'b1, 1'b0}; // JAL
    tbl[5]  = '{7'b1100111, 3'd0, 1'b0, 4, 2'd2, 2'd2, 1'b1, 1'b0}; // JALR
    tbl[6]  = '{7'b0000011, 3'd2, 1'b0, 5, 2'd1, 2'd0, 1'b1, 1'b0}; // LW
    tbl[7]  = '{7'b0100011, 3'd2, 1'b0, 4, 2'd0, 2'd0, 1'b0, 1'b0}; // SW
    tbl[8]  = '{7'b1100011, 3'd1, 1'b0, 3, 2'd0, 2'd1, 1'b0, 1'b0}; // BNE taken
    tbl[9]  = '{7'b1100011, 3'd5, 1'b0, 3, 2'd0, 2'd0, 1'b0, 1'b0}; // BGE not taken
    tbl[10] = '{7'b1100011, 3'd0, 1'b1, 3, 2'd0, 2'd1, 1'b0, 1'b0}; // BEQ taken
    tbl[11] = '{7'b1100011, 3'd4, 1'b0, 3, 2'd0, 2'd1, 1'b0, 1'b0}; // BLT taken
    tbl[12] = '{7'b0001111, 3'd0, 1'b0, 4, 2'd0, 2'd0, 1'b0, 1'b0}; // FENCE
    tbl[13] = '{7'b1110011, 3'd0, 1'b0, 4, 2'd0, 2'd0, 1'b0, 1'b0}; // ECALL
    tbl[14] = '{7'b1111111, 3'd0, 1'b0, 4, 2'd0, 2'd0, 1'b0, 1'b1}; // illegal
    legal_opc = '{7'b0110011, 7'b0010011, 7'b0010111, 7'b0110111, 7'b1101111, 7'b1100111,
                  7'b0000011, 7'b0100011, 7'b1100011, 7'b0001111, 7'b1110011};

    reset = 1'b0;
    mem_ready = 1'b1;
    inst_opcode = 7'b0010011;
    inst_funct3 = 3'd0;
    alu_result_equal_zero = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("reset_outputs", {16'h0, dut_vec()}, 32'h0);
`ifdef INSTRET_COUNTER_EN
      chk("reset_instret", instret, 32'h0);
`endif
      tick();
    end
    reset = 1'b1;

    for (int i = 0; i < 15; i++) run_fixed(tbl[i], i);

    run_instr(7'b0000011, 3'd2, 2, 3);
    chk("lw_wait_latency", obs_cyc, 10);
    chk("lw_read_held", obs_rd, 4);

    run_instr(7'b0010011, 3'd0, 0, 0);
    chk("addi_latency", obs_cyc, 4);

    // Store aborted by reset while waiting in MEM.
    inst_opcode = 7'b0100011; inst_funct3 = 3'd2;
    mem_ready = 1'b1;
    cycle_check("sw_fetch", PH_F, K_STORE);
    mem_ready = 1'b0;
    cycle_check("sw_decode", PH_D, K_STORE);
    cycle_check("sw_execute", PH_E, K_STORE);
    cycle_check("sw_mem_wait", PH_M, K_STORE);
    #1;
    reset = 1'b0;
    #1;
    chk("sw_abort_async", {16'h0, dut_vec()}, 32'h0);
    tick();
    chk("sw_abort_held", {16'h0, dut_vec()}, 32'h0);
    model_instret = '0;
    reset = 1'b1;
    run_instr(7'b0010011, 3'd0, 0, 0);
    chk("restart_latency", obs_cyc, 4);

`ifdef INSTRET_COUNTER_EN
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    model_instret = 32'hFFFF_FFFF;
    run_instr(7'b0010011, 3'd0, 0, 0);
    chk("instret_wrap", instret, 32'h0);
    model_instret = instret === 32'h0 ? 32'h0 : instret;
    #1;
    tick();
`endif

    for (int n = 0; n < 300; n++) begin
      logic [6:0] o;
      o = ($urandom_range(0, 11) == 11) ? 7'($urandom) : legal_opc[$urandom_range(0, 10)];
      run_instr(o, 3'($urandom), -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctlpath.md
Name: multicycle_ctlpath

Overview:
- Control FSM for the multicycle variant of the RISC-V SiMPLE SV core.
- Sequences one instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK over a single shared memory bus that is used for both instruction fetch and data access, with wait states.
- Drives the enables and mux selects of the multicycle datapath.
- Replaces the single-cycle control path when the multicycle core is built.

Parameters:
- RESET_STATE, 0 (FETCH), state entered on reset; must be a legal state encoding.

Ports:
- clock  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- inst_opcode  input  7  opcode field of the latched instruction register.
- inst_funct3  input  3  funct3 field of the latched instruction register.
- alu_result_equal_zero  input  1  ALU result == 0.
- mem_ready  input  1  shared bus has completed the current access this cycle.
- inst_read_enable  output  1  bus instruction read request.
- inst_write_enable  output  1  latch bus data into the instruction register.
- operand_write_enable  output  1  latch rs1/rs2 values into operand registers.
- pc_write_enable  output  1  update PC.
- regfile_write_enable  output  1  write rd.
- data_mem_read_enable  output  1  bus load request.
- data_mem_write_enable  output  1  bus store request.
- alu_operand_a_select  output  1  0 = rs1 register, 1 = PC.
- alu_operand_b_select  output  1  0 = rs2 register, 1 = immediate.
- alu_op_type  output  2  0 = ADD, 1 = branch compare (SUB/SLT/SLTU per funct3), 2 = funct3/bit30 operation.
- reg_writeback_select  output  2  0 = ALU, 1 = memory data, 2 = PC+4, 3 = immediate.
- next_pc_select  output  2  0 = PC+4, 1 = PC+imm, 2 = ALU result with bit0 cleared.
- illegal_inst  output  1  one-cycle pulse in DECODE for an unknown opcode.

Behaviour:
- FSM states: FETCH, DECODE, EXECUTE, MEM, WRITEBACK. State register is the only storage (plus the optional counter).
- While reset=0: state = FETCH and every output = 0, asynchronously. After release, the first FETCH starts on the next edge.
- Outputs are combinational from state, opcode, funct3, alu_result_equal_zero and mem_ready. Selects not listed below = 0.
- FETCH:
  - inst_read_enable=1 held.
  - When mem_ready=1: inst_write_enable=1 and go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - operand_write_enable=1; go to EXECUTE.
  - Unknown opcode: illegal_inst=1, treated as NOP: EXECUTE then WRITEBACK with regfile_write_enable forced 0.
  - MISC_MEM and SYSTEM are also NOPs.
- EXECUTE:
  - OP: a=0, b=0, op=2. Go to WRITEBACK.
  - OP_IMM: a=0, b=1, op=2. Go to WRITEBACK.
  - AUIPC: a=1, b=1, op=0. Go to WRITEBACK.
  - LUI, JAL, NOP: no ALU use. Go to WRITEBACK.
  - JALR: a=0, b=1, op=0. Go to WRITEBACK.
  - LOAD, STORE: a=0, b=1, op=0. Go to MEM.
  - BRANCH: a=0, b=0, op=1, pc_write_enable=1. Go to FETCH.
    - taken = alu_result_equal_zero XOR funct3[0] XOR funct3[2].
    - next_pc_select = taken ? 1 : 0.
- MEM:
  - Load: data_mem_read_enable=1 held until mem_ready; on mem_ready go to WRITEBACK.
  - Store: data_mem_write_enable=1 held until mem_ready; on mem_ready set pc_write_enable=1, next_pc_select=0, go to FETCH.
  - The ALU address inputs are held (same selects as EXECUTE) throughout MEM.
- WRITEBACK:
  - pc_write_enable=1; regfile_write_enable=1 (except for NOPs). Go to FETCH.
  - reg_writeback_select: LOAD=1, JAL/JALR=2, LUI=3, otherwise 0.
  - next_pc_select: JAL=1, JALR=2, otherwise 0.
  - JALR keeps a=0, b=1, op=0 so the jump target stays valid.
- Latency with zero wait states:
  - OP/OP_IMM/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
  - Each cycle with mem_ready=0 adds one cycle.
- Only one bus request (inst, data read, data write) is ever active in a cycle. read and write enable are never 1 together.
- Reset asserted mid-MEM: bus enables drop in the same cycle. The aborted store is not retried; PC is unchanged.
- mem_ready outside FETCH/MEM is ignored.

Optional Feature:
- Macro: INSTRET_COUNTER_EN.
- Defined:
  - Adds output instret, 32 bits.
  - Cleared by reset.
  - Increments by 1 on every edge where pc_write_enable=1, i.e. one per retired instruction, illegal NOPs included.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset low for 3 cycles with mem_ready=1 -> all outputs 0. After release: FETCH with inst_read_enable=1; instret=0.
- ADDI (opcode 0010011), mem_ready=1 -> FETCH, DECODE, EXECUTE (b=1, op=2), WRITEBACK (regfile_write_enable=1, wb_sel=0, next_pc=0); 4 cycles; instret +1.
- LW with mem_ready low 2 cycles in FETCH and 3 in MEM -> 10 cycles total; data_mem_read_enable held 4 cycles; WRITEBACK wb_sel=1.
- BNE (funct3=001), alu_result_equal_zero=0 -> EXECUTE pc_write_enable=1, next_pc_select=1. BGE (101) with zero=0 -> next_pc_select=0.
- JALR -> WRITEBACK: wb_sel=2, next_pc_select=2, a=0, b=1. Opcode 1111111 -> illegal_inst pulse in DECODE, no regfile write, PC+4.
- SW with reset asserted during MEM -> data_mem_write_enable drops immediately; after release, fetch restarts at the unchanged PC. With INSTRET_COUNTER_EN, preload 0xFFFFFFFF and retire one instruction -> instret=0.
